// File: rtl/axi_const_resp_slv_if.sv
// Default AXI request/response struct types and the slave-port interface
// that carries them between a requester and axi_const_resp_slv.
package axi_const_resp_slv_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [5:0]  atop;
    logic        user;
  } aw_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic        user;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic       user;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        user;
  } ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    b_chan_t  b;
    logic     b_valid;
    r_chan_t  r;
    logic     r_valid;
  } resp_t;

endpackage

interface axi_const_resp_slv_if #(
  parameter type req_t  = axi_const_resp_slv_pkg::req_t,
  parameter type resp_t = axi_const_resp_slv_pkg::resp_t
);
  req_t  slv_req_i;
  resp_t slv_resp_o;

  modport master (output slv_req_i, input  slv_resp_o);
  modport slave  (input  slv_req_i, output slv_resp_o);
endinterface

// File: rtl/axi_const_resp_slv.sv
// Terminating AXI4 responder: accepts every request and answers with a fixed
// response code and fixed read data. Macro AXI_CONST_RESP_SLV_ATOP_EN adds R bursts for atomics.
//
// state  | meaning
// W_IDLE | waiting for AW; W back-pressured
// W_DATA | swallowing W beats until w.last
// W_RESP | presenting B until b_ready
// R_IDLE | waiting for AR (or a pending atomic read response)
// R_DATA | streaming beats until the counter reaches zero
module axi_const_resp_slv #(
  parameter type         req_t    = axi_const_resp_slv_pkg::req_t,
  parameter type         resp_t   = axi_const_resp_slv_pkg::resp_t,
  parameter logic [1:0]  RespCode = 2'b11,
  parameter logic [63:0] RespData = 64'hCA11_AB1E_BAD_CAB1E
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  axi_const_resp_slv_if.slave  slv,
  output logic                 busy_o
);

  req_t  req;
  resp_t resp;

  assign req            = slv.slv_req_i;
  assign slv.slv_resp_o = resp;

  localparam int BIdW  = $bits(resp.b.id);
  localparam int RIdW  = $bits(resp.r.id);
  localparam int DataW = $bits(resp.r.data);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [BIdW-1:0] w_id_q, w_id_d;
  logic [RIdW-1:0] r_id_q, r_id_d;
  logic [7:0]      r_cnt_q, r_cnt_d;
  logic            r_atop_q, r_atop_d;

  logic            aw_ready, w_ready, b_valid;
  logic            ar_ready, r_valid;
  logic            aw_hs, r_last_hs;

  logic            atop_pending;
  logic [RIdW-1:0] atop_id;
  logic [7:0]      atop_len;

  // Read data pattern repeats every 64 bits, so it truncates or replicates.
  logic [DataW-1:0] resp_data;
  for (genvar g = 0; g < DataW; g++) begin : g_data
    assign resp_data[g] = RespData[g % 64];
  end

  assign aw_hs = (w_state_q == W_IDLE) && !atop_pending && req.aw_valid;

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_ready = !atop_pending;
        if (aw_hs) begin
          w_id_d    = req.aw.id;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (req.w_valid && req.w.last) w_state_d = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (req.b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_cnt_d   = r_cnt_q;
    r_atop_d  = r_atop_q;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    r_last_hs = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_ready = !atop_pending;
        if (atop_pending) begin
          r_id_d    = atop_id;
          r_cnt_d   = atop_len;
          r_atop_d  = 1'b1;
          r_state_d = R_DATA;
        end else if (req.ar_valid) begin
          r_id_d    = req.ar.id;
          r_cnt_d   = req.ar.len;
          r_atop_d  = 1'b0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        r_valid = 1'b1;
        if (req.r_ready) begin
          if (r_cnt_q == 8'd0) begin
            r_last_hs = 1'b1;
            r_atop_d  = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d = r_cnt_q - 8'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_cnt_q   <= '0;
      r_atop_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_cnt_q   <= r_cnt_d;
      r_atop_q  <= r_atop_d;
    end
  end

`ifdef AXI_CONST_RESP_SLV_ATOP_EN
  logic            atop_pending_q, atop_pending_d;
  logic [RIdW-1:0] atop_id_q, atop_id_d;
  logic [7:0]      atop_len_q, atop_len_d;

  // Only atomics that return data (atop[5]) need an R burst.
  always_comb begin
    atop_pending_d = atop_pending_q;
    atop_id_d      = atop_id_q;
    atop_len_d     = atop_len_q;
    if (aw_hs && req.aw.atop[5]) begin
      atop_pending_d = 1'b1;
      atop_id_d      = req.aw.id;
      atop_len_d     = req.aw.len;
    end
    if (r_last_hs && r_atop_q) atop_pending_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      atop_pending_q <= 1'b0;
      atop_id_q      <= '0;
      atop_len_q     <= '0;
    end else begin
      atop_pending_q <= atop_pending_d;
      atop_id_q      <= atop_id_d;
      atop_len_q     <= atop_len_d;
    end
  end

  assign atop_pending = atop_pending_q;
  assign atop_id      = atop_id_q;
  assign atop_len     = atop_len_q;
`else
  assign atop_pending = 1'b0;
  assign atop_id      = '0;
  assign atop_len     = '0;

  logic unused_atop;
  assign unused_atop = r_atop_q ^ r_last_hs;
`endif

  // Most request payload is deliberately discarded.
  logic unused_req;
  assign unused_req = ^req;

  always_comb begin
    resp          = '0;
    resp.aw_ready = aw_ready & ~rst_i;
    resp.w_ready  = w_ready  & ~rst_i;
    resp.b_valid  = b_valid  & ~rst_i;
    resp.ar_ready = ar_ready & ~rst_i;
    resp.r_valid  = r_valid  & ~rst_i;
    resp.b.id     = w_id_q;
    resp.b.resp   = RespCode;
    resp.r.id     = r_id_q;
    resp.r.data   = resp_data;
    resp.r.resp   = RespCode;
    resp.r.last   = (r_cnt_q == 8'd0);
  end

  assign busy_o = ~rst_i & ((w_state_q != W_IDLE) | (r_state_q != R_IDLE) | atop_pending);

endmodule

// File: tb/tb_axi_const_resp_slv.sv
// Directed bench for axi_const_resp_slv; the atomic scenario's expectations
// follow AXI_CONST_RESP_SLV_ATOP_EN.
module tb_axi_const_resp_slv;
  import axi_const_resp_slv_pkg::*;

  logic  clk_i = 1'b0;
  logic  rst_i = 1'b1;
  logic  busy_o;
  req_t  req;
  resp_t rsp;
  int    checks = 0;
  int    failures = 0;

  localparam logic [31:0] EXP_DATA = 32'hBADC_AB1E;

  axi_const_resp_slv_if #(.req_t(req_t), .resp_t(resp_t)) slv_if ();

  assign slv_if.slv_req_i = req;
  assign rsp = slv_if.slv_resp_o;

  axi_const_resp_slv #(.req_t(req_t), .resp_t(resp_t)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .slv    (slv_if),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    req = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1'b1;
    step();
    step();
    req.aw_valid = 1'b1;
    req.ar_valid = 1'b1;
    req.w_valid  = 1'b1;
    #1;
    checks++;
    if ({rsp.aw_ready, rsp.w_ready, rsp.ar_ready, rsp.b_valid, rsp.r_valid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_hs got=%b exp=00000",
               {rsp.aw_ready, rsp.w_ready, rsp.ar_ready, rsp.b_valid, rsp.r_valid});
    end
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    step();
    idle();
    rst_i = 1'b0;
    #1;
    checks++;
    if ({rsp.aw_ready, rsp.ar_ready} !== 2'b11) begin
      failures++; $display("FAIL post_reset_ready got=%b exp=11", {rsp.aw_ready, rsp.ar_ready});
    end
    checks++;
    if ({rsp.b_valid, rsp.r_valid, busy_o} !== 3'b000) begin
      failures++; $display("FAIL post_reset_valid got=%b exp=000", {rsp.b_valid, rsp.r_valid, busy_o});
    end
  endtask

  task automatic test_write();
    idle();
    req.w_valid = 1'b1;
    checks++;
    if (rsp.w_ready !== 1'b0) begin failures++; $display("FAIL w_before_aw got=%b exp=0", rsp.w_ready); end
    step();
    checks++;
    if (rsp.w_ready !== 1'b0) begin failures++; $display("FAIL w_before_aw2 got=%b exp=0", rsp.w_ready); end
    req.aw_valid = 1'b1;
    req.aw.id    = 4'd5;
    req.aw.len   = 8'd3;
    checks++;
    if (rsp.aw_ready !== 1'b1) begin failures++; $display("FAIL wr_aw_ready got=%b exp=1", rsp.aw_ready); end
    step();
    req.aw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req.w.last = (i == 3);
      checks++;
      if ({rsp.aw_ready, rsp.w_ready, rsp.b_valid} !== 3'b010) begin
        failures++;
        $display("FAIL wr_beat%0d got=%b exp=010", i, {rsp.aw_ready, rsp.w_ready, rsp.b_valid});
      end
      step();
    end
    req.w_valid = 1'b0;
    req.w.last  = 1'b0;
    checks++;
    if ({rsp.b_valid, rsp.w_ready} !== 2'b10) begin
      failures++; $display("FAIL wr_b_valid got=%b exp=10", {rsp.b_valid, rsp.w_ready});
    end
    checks++;
    if (rsp.b !== {4'd5, 2'b11, 1'b0}) begin
      failures++; $display("FAIL wr_b_fields got=%h exp=%h", rsp.b, {4'd5, 2'b11, 1'b0});
    end
    checks++;
    if (busy_o !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b exp=1", busy_o); end
    step();
    checks++;
    if ({rsp.b_valid, rsp.b} !== {1'b1, 4'd5, 2'b11, 1'b0}) begin
      failures++; $display("FAIL wr_b_hold got=%h exp=%h", {rsp.b_valid, rsp.b}, {1'b1, 4'd5, 2'b11, 1'b0});
    end
    req.b_ready = 1'b1;
    step();
    req.b_ready = 1'b0;
    checks++;
    if ({rsp.b_valid, rsp.aw_ready, busy_o} !== 3'b010) begin
      failures++; $display("FAIL wr_done got=%b exp=010", {rsp.b_valid, rsp.aw_ready, busy_o});
    end
  endtask

  task automatic test_read_backpressure();
    logic [4:0] pat;
    r_chan_t    prev_r;
    logic       have_prev;
    int         beats;
    pat       = 5'b10101;
    have_prev = 1'b0;
    beats     = 0;
    prev_r    = '0;
    idle();
    req.ar_valid = 1'b1;
    req.ar.id    = 4'd9;
    req.ar.len   = 8'd2;
    checks++;
    if (rsp.ar_ready !== 1'b1) begin failures++; $display("FAIL rd_ar_ready got=%b exp=1", rsp.ar_ready); end
    step();
    req.ar_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req.r_ready = pat[i];
      checks++;
      if ({rsp.r_valid, rsp.ar_ready} !== 2'b10) begin
        failures++; $display("FAIL rd_valid c%0d got=%b exp=10", i, {rsp.r_valid, rsp.ar_ready});
      end
      checks++;
      if (rsp.r !== {4'd9, EXP_DATA, 2'b11, (beats == 2), 1'b0}) begin
        failures++;
        $display("FAIL rd_fields c%0d got=%h exp=%h", i, rsp.r, {4'd9, EXP_DATA, 2'b11, (beats == 2), 1'b0});
      end
      if (have_prev) begin
        checks++;
        if (rsp.r !== prev_r) begin
          failures++; $display("FAIL rd_stall_stable c%0d got=%h exp=%h", i, rsp.r, prev_r);
        end
      end
      prev_r    = rsp.r;
      have_prev = !pat[i];
      if (rsp.r_valid && pat[i]) beats++;
      step();
    end
    req.r_ready = 1'b0;
    checks++;
    if (beats != 3) begin failures++; $display("FAIL rd_beats got=%0d exp=3", beats); end
    checks++;
    if ({rsp.r_valid, rsp.ar_ready} !== 2'b01) begin
      failures++; $display("FAIL rd_end got=%b exp=01", {rsp.r_valid, rsp.ar_ready});
    end
  endtask

  task automatic test_concurrency();
    idle();
    req.aw_valid = 1'b1;
    req.aw.id    = 4'd1;
    req.ar_valid = 1'b1;
    req.ar.id    = 4'd2;
    req.ar.len   = 8'd1;
    checks++;
    if ({rsp.aw_ready, rsp.ar_ready} !== 2'b11) begin
      failures++; $display("FAIL cc_both_ready got=%b exp=11", {rsp.aw_ready, rsp.ar_ready});
    end
    step();
    idle();
    req.w_valid = 1'b1;
    req.w.last  = 1'b1;
    step();
    idle();
    req.b_ready = 1'b1;
    checks++;
    if ({rsp.b_valid, rsp.b.id, rsp.r_valid, rsp.r.id, rsp.r.last} !== {1'b1, 4'd1, 1'b1, 4'd2, 1'b0}) begin
      failures++;
      $display("FAIL cc_resp got=%h exp=%h", {rsp.b_valid, rsp.b.id, rsp.r_valid, rsp.r.id, rsp.r.last},
               {1'b1, 4'd1, 1'b1, 4'd2, 1'b0});
    end
    step();
    req.b_ready = 1'b0;
    req.r_ready = 1'b1;
    checks++;
    if ({rsp.b_valid, rsp.r_valid, busy_o} !== 3'b011) begin
      failures++; $display("FAIL cc_b_done got=%b exp=011", {rsp.b_valid, rsp.r_valid, busy_o});
    end
    step();
    checks++;
    if ({rsp.r_valid, rsp.r.last, busy_o} !== 3'b111) begin
      failures++; $display("FAIL cc_r_last got=%b exp=111", {rsp.r_valid, rsp.r.last, busy_o});
    end
    step();
    req.r_ready = 1'b0;
    checks++;
    if ({rsp.r_valid, busy_o} !== 2'b00) begin
      failures++; $display("FAIL cc_idle got=%b exp=00", {rsp.r_valid, busy_o});
    end
  endtask

  task automatic test_len255();
    int beats;
    int nlast;
    int last_pos;
    beats    = 0;
    nlast    = 0;
    last_pos = -1;
    idle();
    req.ar_valid = 1'b1;
    req.ar.id    = 4'd7;
    req.ar.len   = 8'd255;
    step();
    req.ar_valid = 1'b0;
    req.r_ready  = 1'b1;
    while (rsp.r_valid && beats < 300) begin
      checks++;
      if (rsp.ar_ready !== 1'b0) begin
        failures++; $display("FAIL l255_ar_ready beat%0d got=%b exp=0", beats, rsp.ar_ready);
      end
      if (rsp.r.last) begin
        nlast++;
        last_pos = beats;
      end
      beats++;
      step();
    end
    req.r_ready = 1'b0;
    checks++;
    if (beats != 256) begin failures++; $display("FAIL l255_beats got=%0d exp=256", beats); end
    checks++;
    if (nlast != 1 || last_pos != 255) begin
      failures++; $display("FAIL l255_last got=count%0d@%0d exp=count1@255", nlast, last_pos);
    end
    checks++;
    if ({rsp.ar_ready, rsp.r_valid} !== 2'b10) begin
      failures++; $display("FAIL l255_after got=%b exp=10", {rsp.ar_ready, rsp.r_valid});
    end
  endtask

  task automatic test_reset_midburst();
    idle();
    req.aw_valid = 1'b1;
    req.aw.id    = 4'd6;
    req.ar_valid = 1'b1;
    req.ar.id    = 4'd4;
    req.ar.len   = 8'd7;
    step();
    idle();
    req.w_valid = 1'b1;
    req.w.last  = 1'b1;
    req.r_ready = 1'b1;
    step();
    req.w_valid = 1'b0;
    checks++;
    if ({rsp.b_valid, rsp.r_valid, rsp.r.last} !== 3'b110) begin
      failures++; $display("FAIL rm_pre got=%b exp=110", {rsp.b_valid, rsp.r_valid, rsp.r.last});
    end
    rst_i = 1'b1;
    step();
    checks++;
    if ({rsp.aw_ready, rsp.ar_ready, rsp.w_ready, rsp.b_valid, rsp.r_valid, busy_o} !== 6'b0) begin
      failures++;
      $display("FAIL rm_in_reset got=%b exp=000000",
               {rsp.aw_ready, rsp.ar_ready, rsp.w_ready, rsp.b_valid, rsp.r_valid, busy_o});
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if ({rsp.aw_ready, rsp.ar_ready, rsp.b_valid, rsp.r_valid, busy_o} !== 5'b11000) begin
      failures++;
      $display("FAIL rm_release got=%b exp=11000",
               {rsp.aw_ready, rsp.ar_ready, rsp.b_valid, rsp.r_valid, busy_o});
    end
    idle();
    req.ar_valid = 1'b1;
    req.ar.id    = 4'd11;
    req.ar.len   = 8'd0;
    step();
    req.ar_valid = 1'b0;
    checks++;
    if ({rsp.r_valid, rsp.r.id, rsp.r.last, rsp.b_valid} !== {1'b1, 4'd11, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL rm_fresh got=%h exp=%h", {rsp.r_valid, rsp.r.id, rsp.r.last, rsp.b_valid},
               {1'b1, 4'd11, 1'b1, 1'b0});
    end
    req.r_ready = 1'b1;
    step();
    req.r_ready = 1'b0;
    checks++;
    if ({rsp.r_valid, busy_o} !== 2'b00) begin
      failures++; $display("FAIL rm_fresh_done got=%b exp=00", {rsp.r_valid, busy_o});
    end
  endtask

  task automatic test_atop();
    logic [3:0] rid [8];
    logic       rlast [8];
    logic [3:0] bid;
    logic       w_done, ar_done, ar_ready_c0;
    int         nb, nr;
    logic [3:0] exp_rid [3];
    logic       exp_rlast [3];
    int         exp_nr;
    logic       exp_ar_c0;
`ifdef AXI_CONST_RESP_SLV_ATOP_EN
    exp_nr = 3; exp_ar_c0 = 1'b0;
    exp_rid[0] = 4'd3; exp_rlast[0] = 1'b0;
    exp_rid[1] = 4'd3; exp_rlast[1] = 1'b1;
    exp_rid[2] = 4'd4; exp_rlast[2] = 1'b1;
`else
    exp_nr = 1; exp_ar_c0 = 1'b1;
    exp_rid[0] = 4'd4; exp_rlast[0] = 1'b1;
    exp_rid[1] = 4'd0; exp_rlast[1] = 1'b0;
    exp_rid[2] = 4'd0; exp_rlast[2] = 1'b0;
`endif
    nb = 0; nr = 0; bid = '0; w_done = 1'b0; ar_done = 1'b0; ar_ready_c0 = 1'b0;
    for (int i = 0; i < 8; i++) begin rid[i] = '0; rlast[i] = 1'b0; end
    idle();
    req.aw_valid = 1'b1;
    req.aw.id    = 4'd3;
    req.aw.len   = 8'd1;
    req.aw.atop  = 6'b100000;
    checks++;
    if (rsp.aw_ready !== 1'b1) begin failures++; $display("FAIL at_aw_ready got=%b exp=1", rsp.aw_ready); end
    step();
    idle();
    req.ar.id  = 4'd4;
    req.ar.len = 8'd0;
    for (int c = 0; c < 20; c++) begin
      req.w_valid  = !w_done;
      req.w.last   = 1'b1;
      req.ar_valid = !ar_done;
      req.b_ready  = 1'b1;
      req.r_ready  = 1'b1;
      if (c == 0) ar_ready_c0 = rsp.ar_ready;
      if (req.w_valid && rsp.w_ready) w_done = 1'b1;
      if (req.ar_valid && rsp.ar_ready) ar_done = 1'b1;
      if (rsp.b_valid) begin bid = rsp.b.id; nb++; end
      if (rsp.r_valid) begin
        if (nr < 8) begin rid[nr] = rsp.r.id; rlast[nr] = rsp.r.last; end
        nr++;
      end
      step();
    end
    idle();
    checks++;
    if (ar_ready_c0 !== exp_ar_c0) begin
      failures++; $display("FAIL at_ar_ready_c0 got=%b exp=%b", ar_ready_c0, exp_ar_c0);
    end
    checks++;
    if (nb != 1 || bid !== 4'd3) begin
      failures++; $display("FAIL at_b got=count%0d id%0d exp=count1 id3", nb, bid);
    end
    checks++;
    if (nr != exp_nr) begin failures++; $display("FAIL at_r_count got=%0d exp=%0d", nr, exp_nr); end
    for (int i = 0; i < 3; i++) begin
      if (i < exp_nr) begin
        checks++;
        if ({rid[i], rlast[i]} !== {exp_rid[i], exp_rlast[i]}) begin
          failures++;
          $display("FAIL at_r_beat%0d got=id%0d last%0b exp=id%0d last%0b", i, rid[i], rlast[i],
                   exp_rid[i], exp_rlast[i]);
        end
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL at_busy got=%b exp=0", busy_o); end
  endtask

  initial begin
    idle();
    test_reset();
    test_write();
    test_read_backpressure();
    test_concurrency();
    test_len255();
    test_reset_midburst();
    test_atop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
